// File: rtl/occupancy_grid_access_ctrl.sv
// Arbitrates the single-port occupancy-grid RAM among map updates, scan-match queries and a sweep clear.
// Latency: query response 1 cycle after grant; update writes 1 cycle after grant; clear takes MAP_WIDTH*MAP_HEIGHT cycles.
// Backpressure: readies are combinational, high only in IDLE for the granted requester; held low during UPD_WRITE and CLEAR.
module occupancy_grid_access_ctrl #(
  parameter int X_BITS     = 8,
  parameter int Y_BITS     = 8,
  parameter int MAP_WIDTH  = 256,
  parameter int MAP_HEIGHT = 256,
  parameter int WORD_SIZE  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear_start,
  output logic                 clear_busy,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [X_BITS-1:0]    upd_x,
  input  logic [Y_BITS-1:0]    upd_y,
  input  logic [WORD_SIZE-1:0] upd_delta,
  input  logic                 qry_valid,
  output logic                 qry_ready,
  input  logic [X_BITS-1:0]    qry_x,
  input  logic [Y_BITS-1:0]    qry_y,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 ram_write_enable,
  output logic [X_BITS-1:0]    ram_x,
  output logic [Y_BITS-1:0]    ram_y,
  output logic [WORD_SIZE-1:0] ram_wdata,
  input  logic [WORD_SIZE-1:0] ram_rdata
);

  // One extra bit so a map dimension equal to 2^BITS still fits as an exclusive limit.
  localparam logic [X_BITS:0]       X_LIM  = (X_BITS+1)'(MAP_WIDTH);
  localparam logic [Y_BITS:0]       Y_LIM  = (Y_BITS+1)'(MAP_HEIGHT);
  localparam logic [X_BITS-1:0]     X_LAST = X_BITS'(MAP_WIDTH - 1);
  localparam logic [Y_BITS-1:0]     Y_LAST = Y_BITS'(MAP_HEIGHT - 1);
  localparam logic [WORD_SIZE-1:0]  W_MAX  = {1'b0, {(WORD_SIZE-1){1'b1}}};
  localparam logic [WORD_SIZE-1:0]  W_MIN  = {1'b1, {(WORD_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, UPD_WRITE, CLEAR} state_t;

  state_t               state;
  logic                 rr_upd;         // 1: update wins the next contested cycle
  logic                 clear_pending;  // clear requested while an update write was in flight
  logic [X_BITS-1:0]    x_cnt;
  logic [Y_BITS-1:0]    y_cnt;
  logic [X_BITS-1:0]    cap_x;
  logic [Y_BITS-1:0]    cap_y;
  logic                 cap_in_range;
  logic [WORD_SIZE-1:0] cap_old;
  logic [WORD_SIZE-1:0] cap_delta;

  logic                 idle;
  logic                 clear_go;
  logic                 upd_grant;
  logic                 qry_grant;
  logic                 upd_in_range;
  logic                 qry_in_range;
  logic [WORD_SIZE:0]   sum;
  logic [WORD_SIZE-1:0] sat_sum;

  assign upd_in_range = ({1'b0, upd_x} < X_LIM) && ({1'b0, upd_y} < Y_LIM);
  assign qry_in_range = ({1'b0, qry_x} < X_LIM) && ({1'b0, qry_y} < Y_LIM);

  // Grant decision: clear beats everything, a lone requester wins, a tie goes to the round-robin favourite.
  always_comb begin
    idle      = !reset && (state == IDLE);
    clear_go  = clear_start || clear_pending;
    upd_grant = idle && !clear_go && upd_valid && (!qry_valid || rr_upd);
    qry_grant = idle && !clear_go && qry_valid && (!upd_valid || !rr_upd);
  end

  assign upd_ready  = upd_grant;
  assign qry_ready  = qry_grant;
  assign clear_busy = !reset && (state == CLEAR);

  // Saturating log-odds add: one guard bit, clamp when the top two bits disagree.
  always_comb begin
    sum = {cap_old[WORD_SIZE-1], cap_old} + {cap_delta[WORD_SIZE-1], cap_delta};
    if (sum[WORD_SIZE] != sum[WORD_SIZE-1]) begin
      sat_sum = sum[WORD_SIZE] ? W_MIN : W_MAX;
    end else begin
      sat_sum = sum[WORD_SIZE-1:0];
    end
  end

  // RAM port mux; everything is forced low during reset so an interrupted update never writes.
  always_comb begin
    ram_write_enable = 1'b0;
    ram_x            = '0;
    ram_y            = '0;
    ram_wdata        = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (upd_grant) begin
            ram_x = upd_x;
            ram_y = upd_y;
          end else if (qry_grant) begin
            ram_x = qry_x;
            ram_y = qry_y;
          end
        end
        UPD_WRITE: begin
          ram_x            = cap_x;
          ram_y            = cap_y;
          ram_write_enable = cap_in_range;
          ram_wdata        = sat_sum;
        end
        CLEAR: begin
          ram_x            = x_cnt;
          ram_y            = y_cnt;
          ram_write_enable = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Access sequencer: state, round-robin pointer, update capture, clear sweep and registered query response.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      rr_upd        <= 1'b1;
      clear_pending <= 1'b0;
      x_cnt         <= '0;
      y_cnt         <= '0;
      cap_x         <= '0;
      cap_y         <= '0;
      cap_in_range  <= 1'b0;
      cap_old       <= '0;
      cap_delta     <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
    end else begin
      rsp_valid <= qry_grant;
      rsp_data  <= (qry_grant && qry_in_range) ? ram_rdata : '0;
      case (state)
        IDLE: begin
          if (clear_go) begin
            state         <= CLEAR;
            x_cnt         <= '0;
            y_cnt         <= '0;
            clear_pending <= 1'b0;
          end else begin
            // A contested cycle always produced a grant, so hand the next tie to the loser.
            if (upd_valid && qry_valid) begin
              rr_upd <= !rr_upd;
            end
            if (upd_grant) begin
              cap_x        <= upd_x;
              cap_y        <= upd_y;
              cap_in_range <= upd_in_range;
              cap_old      <= ram_rdata;
              cap_delta    <= upd_delta;
              state        <= UPD_WRITE;
            end
          end
        end
        UPD_WRITE: begin
          state <= IDLE;
          if (clear_start) begin
            clear_pending <= 1'b1;
          end
        end
        CLEAR: begin
          if (x_cnt == X_LAST) begin
            x_cnt <= '0;
            if (y_cnt == Y_LAST) begin
              y_cnt <= '0;
              state <= IDLE;
            end else begin
              y_cnt <= y_cnt + 1'b1;
            end
          end else begin
            x_cnt <= x_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_occupancy_grid_access_ctrl.sv
// Bench for occupancy_grid_access_ctrl on a 4x4 map of 8-bit cells with a behavioural RAM and map model.
// Latency: checks every cycle at the falling edge against the model.
// Backpressure: requesters hold valid with stable fields until the ready they observe completes the handshake.
module tb_occupancy_grid_access_ctrl;
  localparam int XB = 3;
  localparam int YB = 3;
  localparam int MW = 4;
  localparam int MH = 4;
  localparam int WS = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          clear_start = 1'b0;
  logic          upd_valid = 1'b0;
  logic          qry_valid = 1'b0;
  logic [XB-1:0] upd_x = '0;
  logic [YB-1:0] upd_y = '0;
  logic [WS-1:0] upd_delta = '0;
  logic [XB-1:0] qry_x = '0;
  logic [YB-1:0] qry_y = '0;
  logic          clear_busy, upd_ready, qry_ready, rsp_valid, ram_write_enable;
  logic [WS-1:0] rsp_data, ram_wdata, ram_rdata;
  logic [XB-1:0] ram_x;
  logic [YB-1:0] ram_y;

  occupancy_grid_access_ctrl #(
    .X_BITS(XB), .Y_BITS(YB), .MAP_WIDTH(MW), .MAP_HEIGHT(MH), .WORD_SIZE(WS)
  ) dut (
    .clock(clock), .reset(reset), .clear_start(clear_start), .clear_busy(clear_busy),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_x(upd_x), .upd_y(upd_y), .upd_delta(upd_delta),
    .qry_valid(qry_valid), .qry_ready(qry_ready), .qry_x(qry_x), .qry_y(qry_y),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_write_enable(ram_write_enable), .ram_x(ram_x), .ram_y(ram_y),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Grid RAM: combinational read, write on the rising edge; off-map reads return junk that must never leak out.
  logic [WS-1:0] mem [MW][MH];
  int            wr_count = 0;
  int            last_wx = -1, last_wy = -1;
  logic [WS-1:0] last_wd = '0;

  always_comb begin
    if (int'(ram_x) < MW && int'(ram_y) < MH) ram_rdata = mem[ram_x[1:0]][ram_y[1:0]];
    else                                      ram_rdata = 8'h5A;
  end

  always @(posedge clock) begin
    if (ram_write_enable === 1'b1) begin
      wr_count++;
      last_wx = int'(ram_x);
      last_wy = int'(ram_y);
      last_wd = ram_wdata;
      if (int'(ram_x) < MW && int'(ram_y) < MH) mem[ram_x[1:0]][ram_y[1:0]] = ram_wdata;
    end
  end

  // ---------------- behavioural model ----------------
  logic signed [WS-1:0] ref_map [MW][MH];
  bit                   started = 0;
  bit                   m_uw = 0;       // an accepted update is due to be written this cycle
  bit                   m_rr = 1;       // update wins the next tie
  bit                   m_cp = 0;       // clear owed
  int                   m_cidx = -1;    // cell index being cleared, -1 when not clearing
  int                   m_ux = 0, m_uy = 0;
  logic signed [WS-1:0] m_ud = '0;
  bit                   e_rv = 0;
  logic [WS-1:0]        e_rd = '0;

  function automatic logic [WS-1:0] sat_add(input logic signed [WS-1:0] a, input logic signed [WS-1:0] b);
    int s;
    s = int'(a) + int'(b);
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return WS'(s);
  endfunction

  function automatic bit on_map(input int x, input int y);
    return (x < MW) && (y < MH);
  endfunction

  // Compare the DUT against the model, then advance the model by one clock.
  always @(negedge clock) begin
    bit            gu, gq, e_we, e_busy, both, addr_chk;
    int            ex, ey;
    logic [WS-1:0] ewd;
    gu = 0; gq = 0; e_we = 0; e_busy = 0; addr_chk = 0; ex = 0; ey = 0; ewd = '0;
    both = upd_valid && qry_valid;
    if (!reset) begin
      if (m_cidx >= 0) begin
        e_busy = 1; e_we = 1; ex = m_cidx % MW; ey = m_cidx / MW; addr_chk = 1;
      end else if (m_uw) begin
        e_we = on_map(m_ux, m_uy);
        ex = m_ux; ey = m_uy; addr_chk = e_we;
        if (e_we) ewd = sat_add(ref_map[m_ux[1:0]][m_uy[1:0]], m_ud);
      end else if (!(clear_start || m_cp)) begin
        if (upd_valid && (!qry_valid || m_rr)) begin
          gu = 1; ex = int'(upd_x); ey = int'(upd_y); addr_chk = 1;
        end else if (qry_valid) begin
          gq = 1; ex = int'(qry_x); ey = int'(qry_y); addr_chk = 1;
        end
      end
    end

    if (started) begin
      check("upd_ready", upd_ready, gu);
      check("qry_ready", qry_ready, gq);
      check("ram_write_enable", ram_write_enable, e_we);
      check("clear_busy", clear_busy, e_busy);
      check("rsp_valid", rsp_valid, e_rv);
      check("rsp_data", rsp_data, e_rd);
      if (e_we) check("ram_wdata", ram_wdata, ewd);
      if (addr_chk) begin
        check("ram_x", ram_x, ex);
        check("ram_y", ram_y, ey);
      end else begin
        check("ram_addr_known", $isunknown({ram_x, ram_y}), 0);
      end
    end

    if (reset) begin
      m_uw = 0; m_rr = 1; m_cp = 0; m_cidx = -1; e_rv = 0; e_rd = '0; started = 1;
    end else begin
      e_rv = 0; e_rd = '0;
      if (m_cidx >= 0) begin
        ref_map[ex[1:0]][ey[1:0]] = '0;
        m_cidx++;
        if (m_cidx == MW * MH) m_cidx = -1;
      end else if (m_uw) begin
        if (e_we) ref_map[m_ux[1:0]][m_uy[1:0]] = ewd;
        m_uw = 0;
        if (clear_start) m_cp = 1;
      end else if (clear_start || m_cp) begin
        m_cidx = 0; m_cp = 0;
      end else begin
        if (gu) begin
          m_uw = 1; m_ux = int'(upd_x); m_uy = int'(upd_y); m_ud = upd_delta;
        end
        if (gq) begin
          e_rv = 1;
          e_rd = on_map(int'(qry_x), int'(qry_y)) ? ref_map[qry_x[1:0]][qry_y[1:0]] : '0;
        end
        if (both) m_rr = !m_rr;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic poke(input int x, input int y, input logic [WS-1:0] v);
    mem[x[1:0]][y[1:0]]     = v;
    ref_map[x[1:0]][y[1:0]] = v;
  endtask

  task automatic do_upd(input int x, input int y, input int d);
    bit acc;
    acc = 0;
    upd_valid = 1; upd_x = XB'(x); upd_y = YB'(y); upd_delta = WS'(d);
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clock);
      acc = upd_ready;
      tick();
    end
    upd_valid = 0;
    check("upd_accepted", acc, 1);
    tick();
  endtask

  task automatic do_qry(input int x, input int y, output logic [WS-1:0] d);
    bit acc;
    acc = 0;
    qry_valid = 1; qry_x = XB'(x); qry_y = YB'(y);
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clock);
      acc = qry_ready;
      tick();
    end
    qry_valid = 0;
    check("qry_accepted", acc, 1);
    @(negedge clock);
    check("qry_rsp_valid", rsp_valid, 1);
    d = rsp_data;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WS-1:0] d;
    string         seq;
    int            wc0, busy_cnt;
    bit            ua, qa, acc;

    for (int x = 0; x < MW; x++)
      for (int y = 0; y < MH; y++) poke(x, y, '0);

    // Model pins computed by hand.
    check("model_sat_hi", sat_add(8'sd120, 8'sd20), 8'd127);
    check("model_sat_lo", sat_add(-8'sd120, -8'sd20), 8'h80);

    reset = 1; tick(); tick(); reset = 0;
    @(negedge clock);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_we", ram_write_enable, 0);
    check("reset_busy", clear_busy, 0);
    tick();

    // Fresh map query, nothing written.
    do_qry(2, 1, d);
    check("q21_data", d, 0);
    check("no_writes_yet", wr_count, 0);

    // Plain update then read-back.
    do_upd(1, 3, 5);
    check("w13_x", last_wx, 1);
    check("w13_y", last_wy, 3);
    check("w13_data", last_wd, 5);
    do_qry(1, 3, d);
    check("q13_data", d, 5);

    // Saturation at both ends.
    poke(0, 0, 8'd120);
    do_upd(0, 0, 20);
    check("sat_hi_write", last_wd, 8'd127);
    poke(3, 3, 8'h88);
    do_upd(3, 3, -20);
    check("sat_lo_write", last_wd, 8'h80);

    // Both requesters held from reset: grants must alternate.
    reset = 1;
    upd_valid = 1; upd_x = 2; upd_y = 2; upd_delta = 1;
    qry_valid = 1; qry_x = 2; qry_y = 2;
    tick(); reset = 0;
    seq = "";
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      seq = {seq, upd_ready ? "U" : (qry_ready ? "Q" : "-")};
      tick();
    end
    upd_valid = 0; qry_valid = 0;
    n_tests++;
    if (seq != "U-QU-Q") begin
      n_fail++;
      $display("FAIL rr_sequence: got %s expected U-QU-Q", seq);
    end
    tick();

    // Clear sweep.
    wc0 = wr_count; busy_cnt = 0;
    clear_start = 1; tick(); clear_start = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (clear_busy) busy_cnt++;
      tick();
    end
    check("clear_busy_cycles", busy_cnt, 16);
    check("clear_writes", wr_count - wc0, 16);
    check("clear_last_x", last_wx, 3);
    check("clear_last_y", last_wy, 3);
    for (int x = 0; x < MW; x++)
      for (int y = 0; y < MH; y++) begin
        do_qry(x, y, d);
        check("cleared_cell", d, 0);
      end

    // Reset during the write cycle of an update.
    poke(1, 1, 8'd33);
    upd_valid = 1; upd_x = 1; upd_y = 1; upd_delta = 7;
    acc = 0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clock);
      acc = upd_ready;
      @(posedge clock); #1;
    end
    check("rst_upd_accepted", acc, 1);
    reset = 1; upd_valid = 0;
    wc0 = wr_count;
    @(negedge clock);
    check("rst_no_we", ram_write_enable, 0);
    tick(); reset = 0; tick();
    check("rst_no_write", wr_count - wc0, 0);
    do_qry(1, 1, d);
    check("rst_old_value", d, 33);

    // Off-map update and query.
    wc0 = wr_count;
    do_upd(5, 0, 3);
    check("oor_no_write", wr_count - wc0, 0);
    do_qry(5, 0, d);
    check("oor_query", d, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clock);
      ua = upd_valid && upd_ready;
      qa = qry_valid && qry_ready;
      @(posedge clock); #1;
      if (!upd_valid || ua) begin
        upd_valid = ($urandom_range(0, 2) != 0);
        upd_x     = XB'($urandom_range(0, 5));
        upd_y     = YB'($urandom_range(0, 4));
        upd_delta = WS'($urandom_range(0, 255));
      end
      if (!qry_valid || qa) begin
        qry_valid = ($urandom_range(0, 2) != 0);
        qry_x     = XB'($urandom_range(0, 4));
        qry_y     = YB'($urandom_range(0, 5));
      end
      clear_start = ($urandom_range(0, 299) == 0);
    end
    upd_valid = 0; qry_valid = 0; clear_start = 0;
    for (int i = 0; i < 20; i++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
